// File: rtl/mp_mult_pkg.sv
// Shared defaults, MULT port widths and FSM state encoding for the
// sequential multiprecision multiplier.
package mp_mult_pkg;

    localparam int LIMB_W_DEF   = 16;
    localparam int NLIMB_DEF    = 16;
    localparam int MULT_LAT_DEF = 3;

    // Port widths of the DSP-style MULT instance; limbs are zero-extended up to these.
    localparam int MULT_WA = 25;
    localparam int MULT_WB = 18;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mp_state_t;

endpackage

// File: rtl/MULT.sv
// Pipelined unsigned multiplier modelled on a DSP slice: the product is
// formed in the first register stage and then delayed so that o_p appears
// exactly LATENCY rising edges after i_a/i_b are sampled.
module MULT #(
    parameter int WIDTH_A = 25,
    parameter int WIDTH_B = 18,
    parameter int LATENCY = 3
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       i_ce,
    input  logic [WIDTH_A-1:0]         i_a,
    input  logic [WIDTH_B-1:0]         i_b,
    output logic [WIDTH_A+WIDTH_B-1:0] o_p
);

    localparam int P_W = WIDTH_A + WIDTH_B;

    logic [P_W-1:0] r_pipe [LATENCY];

    // Product register followed by LATENCY-1 delay stages; reset flushes them all.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < LATENCY; k++) begin
                r_pipe[k] <= '0;
            end
        end else if (i_ce) begin
            r_pipe[0] <= P_W'(i_a) * P_W'(i_b);
            for (int k = 1; k < LATENCY; k++) begin
                r_pipe[k] <= r_pipe[k-1];
            end
        end
    end

    assign o_p = r_pipe[LATENCY-1];

endmodule

// File: rtl/mp_mult_seq.sv
// Schoolbook multiprecision multiplier: one limb pair per cycle goes into a
// single pipelined MULT, and each returning partial product is shifted into
// place and summed into a full-width accumulator that doubles as the result.
module mp_mult_seq
    import mp_mult_pkg::*;
#(
    parameter int LIMB_W   = LIMB_W_DEF,
    parameter int NLIMB    = NLIMB_DEF,
    parameter int MULT_LAT = MULT_LAT_DEF
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        start,
    input  logic [NLIMB*LIMB_W-1:0]     a,
    input  logic [NLIMB*LIMB_W-1:0]     b,
    output logic                        busy,
    output logic                        done,
    output logic [2*NLIMB*LIMB_W-1:0]   p
);

    localparam int OP_W  = NLIMB * LIMB_W;
    localparam int PR_W  = 2 * OP_W;
    localparam int CNT_W = (NLIMB > 1) ? $clog2(NLIMB) : 1;
    localparam int SH_W  = CNT_W + 1;
    localparam int DR_W  = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
    localparam int MP_W  = MULT_WA + MULT_WB;

    localparam logic [CNT_W-1:0] LAST_LIMB = CNT_W'(NLIMB - 1);
    localparam logic [DR_W-1:0]  LAST_DRAIN = DR_W'(MULT_LAT - 1);

    mp_state_t        r_state;
    mp_state_t        w_state_next;
    logic [OP_W-1:0]  r_a;
    logic [OP_W-1:0]  r_b;
    logic [CNT_W-1:0] r_i;
    logic [CNT_W-1:0] r_j;
    logic [DR_W-1:0]  r_drain_cnt;
    logic [PR_W-1:0]  r_acc;
    logic             r_vld [MULT_LAT];
    logic [SH_W-1:0]  r_sh  [MULT_LAT];

    logic              w_accept;
    logic              w_issue;
    logic              w_last_pair;
    logic              w_drain_end;
    logic [LIMB_W-1:0] w_limb_a;
    logic [LIMB_W-1:0] w_limb_b;
    logic [MULT_WA-1:0] w_mult_a;
    logic [MULT_WB-1:0] w_mult_b;
    logic [MP_W-1:0]   w_mult_p;
    logic [31:0]       w_shamt;
    logic [PR_W-1:0]   w_addend;

    // A start only counts when the FSM is not already working on an operand pair.
    assign w_accept    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_issue     = (r_state == ST_ISSUE);
    assign w_last_pair = (r_i == LAST_LIMB) && (r_j == LAST_LIMB);
    assign w_drain_end = (r_drain_cnt == LAST_DRAIN);

    // Current limb pair, zero-extended onto the MULT ports.
    assign w_limb_a = r_a[int'(r_i)*LIMB_W +: LIMB_W];
    assign w_limb_b = r_b[int'(r_j)*LIMB_W +: LIMB_W];
    assign w_mult_a = MULT_WA'(w_limb_a);
    assign w_mult_b = MULT_WB'(w_limb_b);

    MULT #(
        .WIDTH_A (MULT_WA),
        .WIDTH_B (MULT_WB),
        .LATENCY (MULT_LAT)
    ) u_mult (
        .CLK  (CLK),
        .RST  (RST),
        .i_ce (1'b1),
        .i_a  (w_mult_a),
        .i_b  (w_mult_b),
        .o_p  (w_mult_p)
    );

    // Partial product aligned to limb position i+j of the result.
    assign w_shamt  = 32'(r_sh[MULT_LAT-1]) * 32'(LIMB_W);
    assign w_addend = PR_W'(w_mult_p) << w_shamt;

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                busy = 1'b1;
                if (w_last_pair) w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (w_drain_end) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = start ? ST_ISSUE : ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Operand capture on an accepted start; held for the whole operation.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_a <= '0;
            r_b <= '0;
        end else if (w_accept) begin
            r_a <= a;
            r_b <= b;
        end
    end

    // Limb pair counters: i (A limb) outer, j (B limb) inner.
    always_ff @(posedge CLK) begin
        if (RST || w_accept) begin
            r_i <= '0;
            r_j <= '0;
        end else if (w_issue) begin
            if (r_j == LAST_LIMB) begin
                r_j <= '0;
                r_i <= w_last_pair ? '0 : r_i + 1'b1;
            end else begin
                r_j <= r_j + 1'b1;
            end
        end
    end

    // Drain counter waits out the MULT pipeline after the last issue.
    always_ff @(posedge CLK) begin
        if (RST || (r_state != ST_DRAIN)) begin
            r_drain_cnt <= '0;
        end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
        end
    end

    // Valid bit and shift amount ride alongside each product through the MULT latency.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < MULT_LAT; k++) begin
                r_vld[k] <= 1'b0;
                r_sh[k]  <= '0;
            end
        end else begin
            r_vld[0] <= w_issue;
            r_sh[0]  <= SH_W'(r_i) + SH_W'(r_j);
            for (int k = 1; k < MULT_LAT; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_sh[k]  <= r_sh[k-1];
            end
        end
    end

    // Accumulator: cleared on accept, full-width add of each returning product.
    always_ff @(posedge CLK) begin
        if (RST || w_accept) begin
            r_acc <= '0;
        end else if (r_vld[MULT_LAT-1]) begin
            r_acc <= r_acc + w_addend;
        end
    end

    assign p = r_acc;

endmodule

// File: tb/tb_mp_mult_seq.sv
// Directed and randomised checks of mp_mult_seq with default parameters.
module tb_mp_mult_seq;

    localparam int OP_W = 256;
    localparam int PR_W = 512;
    localparam int EXP_CYC = 260;
    localparam int MAX_CYC = 400;

    logic            CLK;
    logic            RST;
    logic            start;
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic            busy;
    logic            done;
    logic [PR_W-1:0] p;

    int n_checks;
    int n_fail;

    mp_mult_seq dut (
        .CLK   (CLK),
        .RST   (RST),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Pulse start with the given operands; returns positioned in cycle 1.
    task automatic do_start(input logic [OP_W-1:0] va, input logic [OP_W-1:0] vb);
        start = 1'b1;
        a     = va;
        b     = vb;
        tick();
        start = 1'b0;
    endtask

    // Wait (bounded) for done, counting cycles from the start edge; optionally
    // pulses start with other operands in cycle inj_cyc.
    task automatic wait_done(input int inj_cyc, input logic [OP_W-1:0] ia,
                             input logic [OP_W-1:0] ib,
                             output int cyc, output int busy_errs);
        cyc       = 1;
        busy_errs = 0;
        while (done !== 1'b1 && cyc < MAX_CYC) begin
            if (busy !== 1'b1) busy_errs++;
            if (cyc == inj_cyc) begin
                start = 1'b1;
                a     = ia;
                b     = ib;
            end
            tick();
            start = 1'b0;
            cyc++;
        end
    endtask

    task automatic test_reset();
        RST   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%0b exp=0", done); end
        n_checks++;
        if (p !== '0) begin n_fail++; $display("FAIL reset_p got=%0h exp=0", p); end
        // Reset wins over a simultaneous start.
        start = 1'b1;
        a     = 256'd9;
        b     = 256'd9;
        tick();
        start = 1'b0;
        RST   = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_prio_busy got=%0b exp=0", busy); end
        tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_prio_idle got=%0b exp=0", busy); end
        $display("test_reset done");
    endtask

    task automatic test_one_by_one();
        int cyc;
        int berr;
        do_start(256'd1, 256'd1);
        wait_done(-1, '0, '0, cyc, berr);
        n_checks++;
        if (cyc !== EXP_CYC) begin n_fail++; $display("FAIL one_latency got=%0d exp=%0d", cyc, EXP_CYC); end
        n_checks++;
        if (berr !== 0) begin n_fail++; $display("FAIL one_busy got=%0d low cycles exp=0", berr); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL one_busy_done got=%0b exp=0", busy); end
        n_checks++;
        if (p !== 512'd1) begin n_fail++; $display("FAIL one_p got=%0h exp=1", p); end
        tick();
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL one_done_pulse got=%0b exp=0", done); end
        n_checks++;
        if (p !== 512'd1) begin n_fail++; $display("FAIL one_p_hold got=%0h exp=1", p); end
        $display("test_one_by_one a=1 b=1 cyc=%0d p=%0h", cyc, p);
    endtask

    task automatic test_max();
        int cyc;
        int berr;
        logic [OP_W-1:0] ones;
        logic [PR_W-1:0] exp_p;
        ones  = '1;
        // (2^256-1)^2 = 2^512 - 2^257 + 1 = (2^512-1) - 2^257 + 2
        exp_p = '1;
        exp_p = exp_p - (512'd1 << 257) + 512'd2;
        do_start(ones, ones);
        wait_done(-1, '0, '0, cyc, berr);
        n_checks++;
        if (cyc !== EXP_CYC) begin n_fail++; $display("FAIL max_latency got=%0d exp=%0d", cyc, EXP_CYC); end
        n_checks++;
        if (p !== exp_p) begin n_fail++; $display("FAIL max_p got=%0h exp=%0h", p, exp_p); end
        $display("test_max cyc=%0d", cyc);
    endtask

    task automatic test_limbs();
        int cyc;
        int berr;
        logic [OP_W-1:0] va;
        logic [OP_W-1:0] vb;
        logic [PR_W-1:0] exp_p;
        // a = 2^240 + 0xFFFF, b = 2^16 + 0xFFFF
        va = (256'd1 << 240) + 256'hFFFF;
        vb = (256'd1 << 16) + 256'hFFFF;
        // a*b = 2^256 + 0xFFFF*2^240 + 0xFFFF*2^16 + 0xFFFE0001
        exp_p = (512'd1 << 256) + (512'hFFFF << 240) + (512'hFFFF << 16) + 512'hFFFE0001;
        do_start(va, vb);
        wait_done(-1, '0, '0, cyc, berr);
        n_checks++;
        if (p !== exp_p) begin n_fail++; $display("FAIL limbs_p got=%0h exp=%0h", p, exp_p); end
        $display("test_limbs cyc=%0d", cyc);
    endtask

    task automatic test_start_ignored();
        int cyc;
        int berr;
        logic [OP_W-1:0] va;
        logic [PR_W-1:0] exp_p;
        va    = (256'd1 << 128) + 256'd3;
        exp_p = (512'd7 << 128) + 512'd21;
        do_start(va, 256'd7);
        wait_done(100, '1, '1, cyc, berr);
        n_checks++;
        if (cyc !== EXP_CYC) begin n_fail++; $display("FAIL ignore_latency got=%0d exp=%0d", cyc, EXP_CYC); end
        n_checks++;
        if (berr !== 0) begin n_fail++; $display("FAIL ignore_busy got=%0d low cycles exp=0", berr); end
        n_checks++;
        if (p !== exp_p) begin n_fail++; $display("FAIL ignore_p got=%0h exp=%0h", p, exp_p); end
        tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_idle got=%0b exp=0", busy); end
        $display("test_start_ignored cyc=%0d", cyc);
    endtask

    task automatic test_reset_abort();
        int cyc;
        int berr;
        int spurious;
        do_start(256'd1000, 256'd1000);
        for (int k = 1; k < 150; k++) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        n_checks++;
        if (p !== '0) begin n_fail++; $display("FAIL abort_p got=%0h exp=0", p); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%0b exp=0", busy); end
        spurious = 0;
        for (int k = 0; k < 150; k++) begin
            if (done !== 1'b0 || busy !== 1'b0) spurious++;
            tick();
        end
        n_checks++;
        if (spurious !== 0) begin n_fail++; $display("FAIL abort_quiet got=%0d active cycles exp=0", spurious); end
        do_start(256'd3, 256'd5);
        wait_done(-1, '0, '0, cyc, berr);
        n_checks++;
        if (cyc !== EXP_CYC) begin n_fail++; $display("FAIL abort_latency got=%0d exp=%0d", cyc, EXP_CYC); end
        n_checks++;
        if (p !== 512'd15) begin n_fail++; $display("FAIL abort_p15 got=%0h exp=f", p); end
        $display("test_reset_abort cyc=%0d p=%0h", cyc, p);
    endtask

    task automatic test_back_to_back();
        int cyc;
        int berr;
        do_start(256'd6, 256'd7);
        wait_done(-1, '0, '0, cyc, berr);
        n_checks++;
        if (p !== 512'd42) begin n_fail++; $display("FAIL b2b_first_p got=%0h exp=2a", p); end
        // Start in the DONE cycle.
        do_start(256'd11, 256'd13);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got=%0b exp=1", busy); end
        wait_done(-1, '0, '0, cyc, berr);
        n_checks++;
        if (cyc !== EXP_CYC) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=%0d", cyc, EXP_CYC); end
        n_checks++;
        if (p !== 512'd143) begin n_fail++; $display("FAIL b2b_second_p got=%0h exp=8f", p); end
        $display("test_back_to_back cyc=%0d p=%0h", cyc, p);
    endtask

    task automatic test_random(input int n);
        int cyc;
        int berr;
        logic [OP_W-1:0] va;
        logic [OP_W-1:0] vb;
        logic [PR_W-1:0] exp_p;
        for (int t = 0; t < n; t++) begin
            for (int w = 0; w < OP_W/32; w++) begin
                va[w*32 +: 32] = $urandom;
                vb[w*32 +: 32] = $urandom;
            end
            if (t == 0) va[OP_W-1 -: 32] = 32'hFFFF_FFFF;
            exp_p = PR_W'(va) * PR_W'(vb);
            do_start(va, vb);
            wait_done(-1, '0, '0, cyc, berr);
            n_checks++;
            if (cyc !== EXP_CYC || p !== exp_p) begin
                n_fail++;
                $display("FAIL rand_%0d cyc=%0d p=%0h exp=%0h", t, cyc, p, exp_p);
            end
            tick();
            n_checks++;
            if (done !== 1'b0) begin n_fail++; $display("FAIL rand_pulse_%0d got=%0b exp=0", t, done); end
            $display("test_random %0d cyc=%0d", t, cyc);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        RST      = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        test_reset();
        test_one_by_one();
        test_max();
        test_limbs();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        test_random(30);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
